// File: rtl/afifo_rd_arbiter.sv
// Round-robin read arbiter for the read side of an async FIFO: grants one requester
// at a time, pops up to MAX_BURST words for it and drops the grant on empty timeout.
module afifo_rd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 4,
    parameter int MAX_EMPTY_WAIT = 16
) (
    input  logic                       rclk,
    input  logic                       rrst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       rempty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rinc,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       dvalid,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(NUM_REQ)-1:0] did,
    output logic [NUM_REQ-1:0]         timeout,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [7:0] WAIT_LIMIT  = 8'(MAX_EMPTY_WAIT);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] last;
    logic [IDW-1:0] winner;
    logic [7:0]     burst_cnt;
    logic [7:0]     stall_cnt;
    logic [7:0]     burst_inc;
    logic [7:0]     stall_inc;

    // Offsets are scanned from the farthest down to the nearest so the nearest hit after 'last' wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     l);
        logic [IDW-1:0] pick;
        int             idx;
        pick = l;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(l) + i) % NUM_REQ;
            if (r[idx]) begin
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    assign winner    = rr_pick(req, last);
    assign burst_inc = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
    assign stall_inc = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
    assign rinc      = (state == GRANT) & req[owner] & ~rempty & (burst_cnt < BURST_LIMIT);
    assign busy      = (state != IDLE);

    // The grant is held through RELEASE and cleared on leaving it, giving one idle cycle between owners.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            last      <= IDW'(NUM_REQ - 1);
            burst_cnt <= '0;
            stall_cnt <= '0;
            dvalid    <= 1'b0;
            dout      <= '0;
            did       <= '0;
            timeout   <= '0;
        end else begin
            dvalid  <= 1'b0;
            timeout <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= winner;
                        gnt       <= ONE << winner;
                        burst_cnt <= '0;
                        stall_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rinc) begin
                        dout      <= rdata;
                        did       <= owner;
                        dvalid    <= 1'b1;
                        burst_cnt <= burst_inc;
                        stall_cnt <= '0;
                        if (burst_inc >= BURST_LIMIT) begin
                            state <= RELEASE;
                        end
                    end else if (!req[owner]) begin
                        state <= RELEASE;
                    end else if (rempty) begin
                        stall_cnt <= stall_inc;
                        if (stall_inc >= WAIT_LIMIT) begin
                            timeout <= ONE << owner;
                            state   <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    gnt   <= '0;
                    last  <= owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_rd_arbiter.sv
// Directed bench for afifo_rd_arbiter: a per-cycle vector table for the four-way burst
// rotation, then hand-written sequences for timeout, empty gaps, drops, reset and random traffic.
module tb_afifo_rd_arbiter;

    logic       rclk;
    logic       rrst_n;
    logic [3:0] req;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic [3:0] gnt;
    logic       dvalid;
    logic [7:0] dout;
    logic [1:0] did;
    logic [3:0] timeout;
    logic       busy;

    int pops;
    int base;
    int wr_cnt;
    logic extra_empty;
    int total;
    int passed;

    afifo_rd_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .MAX_EMPTY_WAIT(16)
    ) dut (
        .rclk(rclk), .rrst_n(rrst_n), .req(req), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .gnt(gnt), .dvalid(dvalid), .dout(dout), .did(did),
        .timeout(timeout), .busy(busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO model: data word equals its position since the last load.
    initial pops = 0;
    always @(posedge rclk) if (rinc) pops <= pops + 1;
    assign rempty = (pops >= wr_cnt) || extra_empty;
    assign rdata  = 8'(pops - base);

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       rinc;
        logic       dvalid;
        logic [7:0] dout;
        logic [1:0] did;
        logic       busy;
    } vec_t;

    vec_t vecs[25];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fifo_load(input int n);
        base   = pops;
        wr_cnt = pops + n;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        req = v.req;
        #1;
        tag = $sformatf("vec%0d", idx);
        check_output({tag, ".gnt"}, gnt, v.gnt);
        check_output({tag, ".rinc"}, rinc, v.rinc);
        check_output({tag, ".dvalid"}, dvalid, v.dvalid);
        check_output({tag, ".busy"}, busy, v.busy);
        check_output({tag, ".timeout"}, timeout, 4'b0000);
        if (v.dvalid) begin
            check_output({tag, ".dout"}, dout, v.dout);
            check_output({tag, ".did"}, did, v.did);
        end
        @(negedge rclk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mask;
        int cnt;
        int nexp;
        int err_onehot;
        int err_under;
        int err_valid;
        logic prev_rinc;

        total       = 0;
        passed      = 0;
        req         = 4'b0000;
        extra_empty = 1'b0;
        base        = 0;
        wr_cnt      = 0;
        rrst_n      = 1'b1;

        // Each grant spans IDLE, four popping GRANT cycles and RELEASE.
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 6; k++) begin
                vec_t v;
                v.req    = 4'b1111;
                v.gnt    = (k == 0) ? 4'b0000 : 4'(1 << g);
                v.rinc   = (k >= 1 && k <= 4);
                v.dvalid = (k >= 2);
                v.dout   = (k == 5) ? 8'(4 * g + 3) : 8'(4 * g + k - 2);
                v.did    = 2'(g);
                v.busy   = (k != 0);
                vecs[g * 6 + k] = v;
            end
        end
        vecs[24] = '{req: 4'b0000, gnt: 4'b0000, rinc: 1'b0, dvalid: 1'b0,
                     dout: 8'h00, did: 2'd0, busy: 1'b0};

        // Reset values, with requests pending and data available.
        fifo_load(16);
        req = 4'b1111;
        @(negedge rclk);
        rrst_n = 1'b0;
        #1;
        check_output("rst.gnt", gnt, 4'b0000);
        check_output("rst.rinc", rinc, 1'b0);
        check_output("rst.dvalid", dvalid, 1'b0);
        check_output("rst.dout", dout, 8'h00);
        check_output("rst.did", did, 2'd0);
        check_output("rst.timeout", timeout, 4'b0000);
        check_output("rst.busy", busy, 1'b0);
        @(negedge rclk);
        rrst_n = 1'b1;

        $display("[TB] burst rotation table");
        for (int i = 0; i < 25; i++) apply_stimulus(vecs[i], i);
        check_output("rot.words_popped", pops - base, 16);

        $display("[TB] empty timeout");
        do_reset();
        fifo_load(0);
        req = 4'b0100;
        #1;
        check_output("to.idle_gnt", gnt, 4'b0000);
        @(negedge rclk);
        for (int c = 1; c <= 16; c++) begin
            #1;
            check_output($sformatf("to.c%0d.rinc", c), rinc, 1'b0);
            check_output($sformatf("to.c%0d.timeout", c), timeout, 4'b0000);
            @(negedge rclk);
        end
        #1;
        check_output("to.pulse", timeout, 4'b0100);
        check_output("to.pulse_gnt", gnt, 4'b0100);
        req = 4'b0000;
        @(negedge rclk);
        #1;
        check_output("to.after_timeout", timeout, 4'b0000);
        check_output("to.after_gnt", gnt, 4'b0000);
        check_output("to.after_busy", busy, 1'b0);

        $display("[TB] empty gap inside a burst");
        do_reset();
        fifo_load(2);
        req  = 4'b0010;
        mask = 0;
        cnt  = 0;
        nexp = 0;
        @(negedge rclk);
        for (int c = 1; c <= 11; c++) begin
            if (c == 8) wr_cnt = wr_cnt + 3;
            #1;
            if (timeout != 4'b0000) cnt++;
            if (dvalid) begin
                mask = mask | (1 << c);
                check_output($sformatf("gap.dout%0d", nexp), dout, 8'(nexp));
                check_output($sformatf("gap.did%0d", nexp), did, 2'd1);
                nexp++;
            end
            if (c == 11) req = 4'b0000;
            @(negedge rclk);
        end
        check_output("gap.dvalid_pattern", mask, 32'h0000_060C);
        check_output("gap.no_timeout", cnt, 0);

        $display("[TB] requester drop mid-burst");
        do_reset();
        fifo_load(8);
        req  = 4'b0100;
        cnt  = 0;
        @(negedge rclk);
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) req = 4'b0000;
            #1;
            if (dvalid && did == 2'd2) cnt++;
            if (c == 3) check_output("drop.rinc_after_drop", rinc, 1'b0);
            if (c == 4) check_output("drop.release_busy", busy, 1'b1);
            if (c == 5) check_output("drop.idle_busy", busy, 1'b0);
            if (c == 5) check_output("drop.idle_gnt", gnt, 4'b0000);
            @(negedge rclk);
        end
        check_output("drop.dvalid_count", cnt, 2);

        $display("[TB] reset mid-burst");
        fifo_load(8);
        req = 4'b0010;
        @(negedge rclk);
        #1;
        check_output("mid.gnt", gnt, 4'b0010);
        @(negedge rclk);
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        check_output("mid.rst_gnt", gnt, 4'b0000);
        check_output("mid.rst_dvalid", dvalid, 1'b0);
        check_output("mid.rst_rinc", rinc, 1'b0);
        check_output("mid.rst_busy", busy, 1'b0);
        @(negedge rclk);
        rrst_n = 1'b1;
        req = 4'b1111;
        @(negedge rclk);
        #1;
        check_output("mid.first_gnt", gnt, 4'b0001);
        check_output("mid.no_timeout", timeout, 4'b0000);

        $display("[TB] random traffic");
        req = 4'b0000;
        do_reset();
        fifo_load(1000000);
        err_onehot = 0;
        err_under  = 0;
        err_valid  = 0;
        prev_rinc  = 1'b0;
        cnt        = pops;
        for (int c = 0; c < 3000; c++) begin
            req         = 4'($urandom);
            extra_empty = ($urandom_range(0, 3) == 0);
            #1;
            if ((gnt & (gnt - 4'd1)) != 4'b0000) err_onehot++;
            if (rinc && rempty) err_under++;
            if (dvalid !== prev_rinc) err_valid++;
            prev_rinc = rinc;
            @(negedge rclk);
        end
        extra_empty = 1'b0;
        check_output("rand.gnt_onehot", err_onehot, 0);
        check_output("rand.no_underflow", err_under, 0);
        check_output("rand.pop_to_dvalid", err_valid, 0);
        check_output("rand.some_pops", (pops - cnt) > 100, 1);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
